spike_rate_decoder: RTL

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

---
 rtl/lif_pkg.sv | 21 ++
 rtl/spike_rate_decoder_if.sv | 36 +++
 rtl/spike_edge_counter.sv | 44 ++++
 rtl/spike_rate_decoder.sv | 105 ++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared constants and types for the spike-rate decoder: channel count,
// default window size, count-width derivation and the result-holding state.
package lif_pkg;

    localparam int NUM_CH       = 4;
    localparam int CH_IDX_W     = $clog2(NUM_CH);
    localparam int WIN_LOG2_DEF = 4;

    // One extra bit so a count of 2^WIN_LOG2 would still fit.
    function automatic int cnt_w_of(input int win_log2);
        return win_log2 + 1;
    endfunction

    localparam int CNT_W_DEF = cnt_w_of(WIN_LOG2_DEF);

    typedef enum logic {
        RES_EMPTY,
        RES_FULL
    } res_state_t;

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Spike inputs, window enable and the valid/ready result channel of the decoder.
interface spike_rate_decoder_if
    import lif_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic                      en;
    logic [NUM_CH-1:0]         spike_in;
    logic                      res_ready;
    logic                      res_valid;
    logic [NUM_CH*CNT_W-1:0]   rate;
    logic [CH_IDX_W-1:0]       winner;
    logic                      overrun;

    modport master (
        input  en,
        input  spike_in,
        input  res_ready,
        output res_valid,
        output rate,
        output winner,
        output overrun
    );

    modport slave (
        output en,
        output spike_in,
        output res_ready,
        input  res_valid,
        input  rate,
        input  winner,
        input  overrun
    );

endinterface

// File: rtl/spike_edge_counter.sv
// One channel: registers the spike line, detects rising edges and counts them
// with a synchronous clear at window close.
module spike_edge_counter
    import lif_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             spike,
    input  logic             clear,
    output logic [CNT_W-1:0] count_next
);

    logic             spike_p0;
    logic             spike_p1;
    logic             evt;
    logic [CNT_W-1:0] count_q;

    // Stage p0: input sample; p1: previous sample for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            spike_p0 <= 1'b0;
            spike_p1 <= 1'b0;
        end else begin
            spike_p0 <= spike;
            spike_p1 <= spike_p0;
        end
    end

    assign evt        = en & spike_p0 & ~spike_p1;
    assign count_next = count_q + CNT_W'(evt);

    // Count stage: on clear the current event goes out via count_next, not into the next window
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder: counts rising edges per channel over 2^WIN_LOG2
// enabled cycles and hands each window's counts plus the busiest channel to a consumer.
module spike_rate_decoder
    import lif_pkg::*;
#(
    parameter  int WIN_LOG2 = WIN_LOG2_DEF,
    localparam int CNT_W    = cnt_w_of(WIN_LOG2)
) (
    input  logic                  clk,
    input  logic                  reset,
    spike_rate_decoder_if.master  bus
);

    logic [WIN_LOG2-1:0]       win_cnt;
    logic                      close;
    logic [NUM_CH*CNT_W-1:0]   counts_next;
    logic [NUM_CH*CNT_W-1:0]   rate_q;
    logic [CH_IDX_W-1:0]       winner_q;
    logic                      overrun_q;
    logic                      overrun_set;
    res_state_t                res_state;
    res_state_t                res_state_nxt;

    // Strict greater-than keeps the lowest index on ties.
    function automatic logic [CH_IDX_W-1:0] pick_winner(input logic [NUM_CH*CNT_W-1:0] counts);
        logic [CH_IDX_W-1:0] best;
        logic [CNT_W-1:0]    best_cnt;
        best     = '0;
        best_cnt = counts[CNT_W-1:0];
        for (int i = 1; i < NUM_CH; i++) begin
            if (counts[i*CNT_W +: CNT_W] > best_cnt) begin
                best     = CH_IDX_W'(i);
                best_cnt = counts[i*CNT_W +: CNT_W];
            end
        end
        return best;
    endfunction

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        spike_edge_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk        (clk),
            .reset      (reset),
            .en         (bus.en),
            .spike      (bus.spike_in[ch]),
            .clear      (close),
            .count_next (counts_next[ch*CNT_W +: CNT_W])
        );
    end

    assign close = bus.en && (win_cnt == '1);

    always_comb begin
        res_state_nxt = res_state;
        overrun_set   = 1'b0;
        case (res_state)
            RES_EMPTY: begin
                if (close) begin
                    res_state_nxt = RES_FULL;
                end
            end
            RES_FULL: begin
                if (close) begin
                    res_state_nxt = RES_FULL;
                    overrun_set   = ~bus.res_ready;
                end else if (bus.res_ready) begin
                    res_state_nxt = RES_EMPTY;
                end
            end
            default: begin
                res_state_nxt = RES_EMPTY;
            end
        endcase
    end

    // Result stage: window counter, result registers and handshake state
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt   <= '0;
            res_state <= RES_EMPTY;
            rate_q    <= '0;
            winner_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.en) begin
                win_cnt <= win_cnt + WIN_LOG2'(1);
            end
            res_state <= res_state_nxt;
            if (close) begin
                rate_q   <= counts_next;
                winner_q <= pick_winner(counts_next);
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.res_valid = (res_state == RES_FULL);
    assign bus.rate      = rate_q;
    assign bus.winner    = winner_q;
    assign bus.overrun   = overrun_q;

endmodule
